multi_wave_gen: RTL and testbench
=================================

MULTI_WAVE_GEN -- requirements
Module: multi_wave_gen

Interface
REQ-001 SHALL have parameter ACC_W, default 24, meaning phase-accumulator width in bits.
REQ-002 SHALL have parameter OUT_W, default 12, meaning signed sample width, with OUT_W <= ACC_W.
REQ-003 SHALL have parameter AMP_W, default 8, meaning unsigned amplitude-control width.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have port en_i  input  1  meaning accumulator advance enable.
REQ-007 SHALL have port ftw_i  input  ACC_W  meaning frequency tuning word, added per enabled cycle.
REQ-008 SHALL have port mode_i  input  2  meaning requested waveform: 0 saw-up, 1 saw-down, 2 triangle, 3 square.
REQ-009 SHALL have port amp_i  input  AMP_W  meaning amplitude, with full-scale value 2^AMP_W-1.
REQ-010 SHALL have port wave_o  output  OUT_W signed  meaning the sample.
REQ-011 SHALL have port valid_o  output  1  meaning wave_o holds a sample from an enabled cycle.
REQ-012 SHALL have port sync_o  output  1  meaning one-cycle pulse marking the first sample of each period.

Function
REQ-013 SHALL update acc <= acc + ftw_i (mod 2^ACC_W) on each en_i=1 cycle and hold acc when en_i=0.
REQ-014 SHALL flag wrap when the addition carries out of ACC_W bits; ftw_i=0 never wraps.
REQ-015 SHALL take p = acc[ACC_W-1 -: OUT_W], unsigned, as the shaping phase.
REQ-016 SHALL compute saw-up as p with its MSB inverted (p=0 -> -2^(OUT_W-1); p=max -> 2^(OUT_W-1)-1).
REQ-017 SHALL compute saw-down as the bitwise NOT of saw-up.
REQ-018 SHALL compute triangle as t=(p<<1) mod 2^OUT_W, bitwise-inverted when p MSB=1, then MSB-inverted.
REQ-019 SHALL output square as 2^(OUT_W-1)-1 when p MSB=0 and -2^(OUT_W-1) otherwise.
REQ-020 SHALL register mode_i into mode_act only on a wrap cycle, or on any cycle when en_i=0; mode_i SHALL NOT take effect mid-period.
REQ-021 SHALL form the pipeline as stage 1 acc, stage 2 shaped sample, stage 3 amplitude-scaled sample.
REQ-022 SHALL make an acc value written at edge k appear on wave_o after edge k+2.
REQ-023 SHALL scale the sample as (s * (amp_i+1)) >>> AMP_W with an arithmetic shift; amp_i at full scale SHALL pass s unchanged.
REQ-024 SHALL pipeline valid_o and sync_o alongside their sample; sync_o SHALL be high for the first sample after a wrap.
REQ-025 SHALL keep the pipeline running when en_i=0, repeating the held sample with valid_o=0.

Reset
REQ-026 SHALL clear acc, wave_o, valid_o and sync_o to 0 and set mode_act to 0 (saw-up) on rst=1 at a clock edge.
REQ-027 SHALL let rst override en_i and mid-period state; the first valid_o SHALL follow 3 edges after rst falls with en_i=1.

Configuration
REQ-028 SHALL enable the stage-3 amplitude multiplier when macro WAVEGEN_AMPLITUDE_EN is defined.
REQ-029 SHALL, without WAVEGEN_AMPLITUDE_EN, ignore amp_i, remove stage 3, and make the latency edge k+1; all other behaviour is unchanged.

Structure
REQ-030 SHALL place the mode encoding (typedef) and the default ACC_W, OUT_W and AMP_W constants in shared package wavegen_pkg.
REQ-031 SHALL implement the waveform shaping of REQ-016 to REQ-019 in sub-module wave_shaper, containing stage 2 only.

Verification (ACC_W=16, OUT_W=12, AMP_W=8, macro defined unless stated)
REQ-032 SHALL cover: reset, then en_i=1, ftw=16, mode 0, amp=255 -> wave_o = -2048, -2047, ... from the third edge; after 4096 samples, sync_o=1 with wave_o=-2048.
REQ-033 SHALL cover: mode 3, ftw=16 -> 2048 samples of +2047 followed by 2048 samples of -2048; mode 2 -> peak 2047 at p=2048.
REQ-034 SHALL cover: mode_i changed 0->2 at p=100 -> saw-up continues until wrap, then triangle starts at -2048, with sync_o=1 at that sample.
REQ-035 SHALL cover: amp=127, saw-up -> p=4095 gives 1023 and p=0 gives -1024.
REQ-036 SHALL cover: rst pulsed mid-period -> next edge shows wave_o=0, valid_o=0, sync_o=0; restart matches REQ-032.
REQ-037 SHALL cover: macro undefined -> latency of 2 edges, and amp=0 still yields full-scale samples.

Source files
------------

// File: rtl/wavegen_pkg.sv
// Shared definitions for the multi-waveform generator.
// Contents:
//   wave_mode_e - waveform selector encoding (saw-up, saw-down, triangle, square)
//   *_W_DEF     - default accumulator, sample and amplitude widths
package wavegen_pkg;

    localparam int ACC_W_DEF = 24;
    localparam int OUT_W_DEF = 12;
    localparam int AMP_W_DEF = 8;

    typedef enum logic [1:0] {
        MODE_SAW_UP = 2'd0,
        MODE_SAW_DN = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SQUARE = 2'd3
    } wave_mode_e;

endpackage

// File: rtl/wave_shaper.sv
// Waveform shaping stage: turns the unsigned phase into a signed sample of the
// selected shape and registers it.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears the sample)
//   phase     - unsigned phase, top OUT_W bits of the accumulator
//   mode      - active waveform
//   sample    - registered signed sample
module wave_shaper
    import wavegen_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OUT_W-1:0]        phase,
    input  wave_mode_e              mode,
    output logic signed [OUT_W-1:0] sample
);

    localparam int MSB = OUT_W - 1;

    logic [OUT_W-1:0] saw;
    logic [OUT_W-1:0] tri_t;
    logic [OUT_W-1:0] shaped;

    always_comb begin
        // Flipping the MSB maps unsigned 0..max onto signed min..max.
        saw   = {~phase[MSB], phase[MSB-1:0]};
        // Double the phase and fold the second half back down.
        tri_t = {phase[MSB-1:0], 1'b0};
        if (phase[MSB]) begin
            tri_t = ~tri_t;
        end
        shaped = saw;
        case (mode)
            MODE_SAW_UP: shaped = saw;
            MODE_SAW_DN: shaped = ~saw;
            MODE_TRI:    shaped = {~tri_t[MSB], tri_t[MSB-1:0]};
            MODE_SQUARE: shaped = {phase[MSB], {(OUT_W-1){~phase[MSB]}}};
            default:     shaped = saw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample <= '0;
        end else begin
            sample <= shaped;
        end
    end

endmodule

// File: rtl/multi_wave_gen.sv
// Multi-waveform generator: phase accumulator (stage 1), waveform shaper
// (stage 2) and optional amplitude scaler (stage 3).
// Configuration macro: WAVEGEN_AMPLITUDE_EN - when defined, stage 3 scales the
//   sample by (amp_i+1)/2^AMP_W; otherwise amp_i is ignored and the sample is
//   taken straight from stage 2.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   en_i      - advance the accumulator this cycle
//   ftw_i     - frequency tuning word
//   mode_i    - requested waveform (applied at period boundaries or while idle)
//   amp_i     - amplitude, full scale 2^AMP_W-1
//   wave_o    - signed sample
//   valid_o   - wave_o comes from an enabled cycle
//   sync_o    - first sample of a new period
module multi_wave_gen
    import wavegen_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int AMP_W = AMP_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic [ACC_W-1:0]        ftw_i,
    input  logic [1:0]              mode_i,
    input  logic [AMP_W-1:0]        amp_i,
    output logic signed [OUT_W-1:0] wave_o,
    output logic                    valid_o,
    output logic                    sync_o
);

`ifdef WAVEGEN_AMPLITUDE_EN
    localparam int STAGES = 3;
`else
    localparam int STAGES = 2;
`endif

    logic [ACC_W-1:0]        acc;
    logic [ACC_W:0]          sum;
    logic                    wrap;
    wave_mode_e              mode_act;
    logic [STAGES:1]         vld_pipe;
    logic [STAGES:1]         sync_pipe;
    logic signed [OUT_W-1:0] shaped;

    assign sum  = {1'b0, acc} + {1'b0, ftw_i};
    assign wrap = en_i & sum[ACC_W];

    // Stage 1: accumulator, mode latch and the tag pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            mode_act  <= MODE_SAW_UP;
            vld_pipe  <= '0;
            sync_pipe <= '0;
        end else begin
            if (en_i) begin
                acc <= sum[ACC_W-1:0];
            end
            // Mode changes land together with the wrapped phase so a period
            // is never split between two shapes.
            if (wrap || !en_i) begin
                mode_act <= wave_mode_e'(mode_i);
            end
            vld_pipe  <= {vld_pipe[STAGES-1:1], en_i};
            sync_pipe <= {sync_pipe[STAGES-1:1], wrap};
        end
    end

    // Stage 2: shaping.
    wave_shaper #(
        .OUT_W (OUT_W)
    ) u_shaper (
        .clk    (clk),
        .rst    (rst),
        .phase  (acc[ACC_W-1 -: OUT_W]),
        .mode   (mode_act),
        .sample (shaped)
    );

`ifdef WAVEGEN_AMPLITUDE_EN
    // Stage 3: multiply by amp+1 so full-scale amplitude is an exact pass.
    localparam int PW = OUT_W + AMP_W + 2;

    logic [AMP_W:0]       amp_p1;
    logic signed [PW-1:0] s_ext;
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] prod;
    logic                 unused_prod;

    assign amp_p1      = {1'b0, amp_i} + {{AMP_W{1'b0}}, 1'b1};
    assign s_ext       = PW'(shaped);
    assign a_ext       = $signed(PW'(amp_p1));
    assign prod        = s_ext * a_ext;
    assign unused_prod = ^{prod[PW-1:AMP_W+OUT_W], prod[AMP_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            wave_o <= '0;
        end else begin
            // Slice at AMP_W is the arithmetic right shift; product never
            // exceeds the OUT_W signed range because amp+1 <= 2^AMP_W.
            wave_o <= prod[AMP_W +: OUT_W];
        end
    end
`else
    logic unused_amp;

    assign unused_amp = ^amp_i;
    assign wave_o     = shaped;
`endif

    assign valid_o = vld_pipe[STAGES];
    assign sync_o  = sync_pipe[STAGES];

endmodule

// File: tb/tb_multi_wave_gen.sv
module tb_multi_wave_gen;

    localparam int ACC_W = 16;
    localparam int OUT_W = 12;
    localparam int AMP_W = 8;
    localparam int HALF  = 1 << (OUT_W - 1);
`ifdef WAVEGEN_AMPLITUDE_EN
    localparam int LAT    = 2;
    localparam bit AMP_ON = 1'b1;
`else
    localparam int LAT    = 1;
    localparam bit AMP_ON = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    en_i;
    logic [ACC_W-1:0]        ftw_i;
    logic [1:0]              mode_i;
    logic [AMP_W-1:0]        amp_i;
    logic signed [OUT_W-1:0] wave_o;
    logic                    valid_o;
    logic                    sync_o;

    always #5 clk = ~clk;

    multi_wave_gen #(.ACC_W(ACC_W), .OUT_W(OUT_W), .AMP_W(AMP_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en_i),
        .ftw_i   (ftw_i),
        .mode_i  (mode_i),
        .amp_i   (amp_i),
        .wave_o  (wave_o),
        .valid_o (valid_o),
        .sync_o  (sync_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: phase as an integer, shapes from their defining formulas,
    // and a queue of samples in flight (depth = latency).
    typedef struct {
        bit known;
        int s;
        bit v;
        bit y;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   macc;
    int   mmode;

    function automatic int shape(int p, int m);
        case (m)
            0:       return p - HALF;
            1:       return HALF - 1 - p;
            2:       return (p < HALF) ? 2 * p - HALF : 3 * HALF - 1 - 2 * p;
            default: return (p < HALF) ? HALF - 1 : -HALF;
        endcase
    endfunction

    function automatic int scale(int s, int a);
        if (AMP_ON) return (s * (a + 1)) >>> AMP_W;
        return s;
    endfunction

    task automatic chk(string tag, logic signed [31:0] obs, int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        int  nsum;
        bit  w;
        if (rst) begin
            macc  = 0;
            mmode = 0;
            q.delete();
            for (int i = 0; i < LAT - 1; i++) q.push_back('{1'b0, 0, 1'b0, 1'b0});
            q.push_back('{1'b1, shape(0, 0), 1'b0, 1'b0});
            cur = '{1'b1, 0, 1'b0, 1'b0};
        end else begin
            nsum = macc + int'(ftw_i);
            w    = en_i && (nsum >= (1 << ACC_W));
            if (en_i) macc = nsum % (1 << ACC_W);
            if (w || !en_i) mmode = int'(mode_i);
            q.push_back('{1'b1, shape(macc >> (ACC_W - OUT_W), mmode), en_i, w});
            cur = q.pop_front();
            if (cur.known) cur.s = scale(cur.s, int'(amp_i));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("valid", {31'b0, valid_o}, int'(cur.v));
        chk("sync", {31'b0, sync_o}, int'(cur.y));
        if (cur.known) chk("wave", wave_o, cur.s);
    endtask

    task automatic wait_sync(output int n, output logic signed [31:0] prev);
        n    = 0;
        prev = 0;
        do begin
            prev = wave_o;
            step();
            n++;
        end while (!sync_o && n < 5000);
        chk("sync_seen", {31'b0, sync_o}, 1);
    endtask

    // Start from reset with ftw=16 saw-up; phase 0 lands at edge LAT (invalid),
    // phase 1 is the first valid sample one edge later.
    task automatic restart_check(string tag);
        rst    = 1'b0;
        en_i   = 1'b1;
        ftw_i  = 16;
        mode_i = 2'd0;
        amp_i  = 8'd255;
        for (int i = 0; i < LAT; i++) step();
        chk({tag, "_p0_wave"}, wave_o, -2048);
        chk({tag, "_p0_valid"}, {31'b0, valid_o}, 0);
        step();
        chk({tag, "_first_wave"}, wave_o, -2047);
        chk({tag, "_first_valid"}, {31'b0, valid_o}, 1);
    endtask

    initial begin
        int n;
        int pos;
        int neg;
        int mx;
        logic signed [31:0] prev;

        rst    = 1'b1;
        en_i   = 1'b1;
        ftw_i  = 16'd1234;
        mode_i = 2'd3;
        amp_i  = 8'd255;
        step();
        step();
        chk("rst_wave", wave_o, 0);
        chk("rst_valid", {31'b0, valid_o}, 0);
        chk("rst_sync", {31'b0, sync_o}, 0);

        // Saw-up period: wrap after 4096 writes.
        restart_check("start");
        wait_sync(n, prev);
        chk("saw_period", n, 4095);
        chk("saw_sync_wave", wave_o, -2048);
        chk("saw_last_wave", prev, 2047);

        // Square: request takes effect at the next wrap.
        mode_i = 2'd3;
        wait_sync(n, prev);
        chk("sq_wait", n, 4096);
        mode_i = 2'd2;
        pos = 0;
        neg = 0;
        for (int i = 0; i < 4096; i++) begin
            if (i > 0) step();
            if (wave_o == 2047) pos++;
            if (wave_o == -2048) neg++;
        end
        chk("sq_pos", pos, 2048);
        chk("sq_neg", neg, 2048);

        // Triangle.
        step();
        chk("tri_sync", {31'b0, sync_o}, 1);
        chk("tri_start", wave_o, -2048);
        mode_i = 2'd0;
        mx = -100000;
        for (int i = 0; i < 4095; i++) begin
            step();
            if (wave_o > mx) mx = wave_o;
        end
        chk("tri_peak", mx, 2047);

        // Mode change 0->2 mid-period at p=100.
        wait_sync(n, prev);
        chk("saw2_start", wave_o, -2048);
        n = 0;
        while ((macc >> (ACC_W - OUT_W)) != 100 && n < 5000) begin
            step();
            n++;
        end
        chk("reach_p100", macc >> (ACC_W - OUT_W), 100);
        mode_i = 2'd2;
        wait_sync(n, prev);
        chk("chg_last_saw", prev, 2047);
        chk("chg_tri_start", wave_o, -2048);
        step();
        chk("chg_tri_next", wave_o, -2046);

        // Half amplitude on saw-up.
        mode_i = 2'd0;
        wait_sync(n, prev);
        amp_i = 8'd127;
        wait_sync(n, prev);
        chk("amp_top", prev, AMP_ON ? 1023 : 2047);
        chk("amp_bottom", wave_o, AMP_ON ? -1024 : -2048);
        amp_i = 8'd0;
        step();
        chk("amp0", wave_o, scale(-2047, 0));

        // Randomised run against the model.
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 199) == 0);
            en_i   = ($urandom_range(0, 9) < 8);
            ftw_i  = 16'($urandom_range(0, 4000));
            if ($urandom_range(0, 49) == 0) ftw_i = 16'($urandom_range(60000, 65535));
            mode_i = 2'($urandom_range(0, 3));
            amp_i  = 8'($urandom_range(0, 255));
            step();
        end

        // Reset mid-period, then restart.
        rst    = 1'b0;
        en_i   = 1'b1;
        ftw_i  = 16;
        mode_i = 2'd1;
        for (int i = 0; i < 500; i++) step();
        rst = 1'b1;
        step();
        chk("midrst_wave", wave_o, 0);
        chk("midrst_valid", {31'b0, valid_o}, 0);
        chk("midrst_sync", {31'b0, sync_o}, 0);
        restart_check("again");
        for (int i = 0; i < 20; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
